// File: rtl/fetch_unit.sv
// Program-counter and fetch sequencer: holds the PC, sequences IDLE/RUN/HALT,
// resolves absolute or PC-relative taken branches and counts retired instructions.
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic             branch_rel,
  input  logic [7:0]       branch_val,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Wide enough to hold the 8-bit branch value and the PC without losing bits.
  localparam int EXT_W = (PC_W > 8) ? PC_W : 8;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              done_q, done_d;

  logic [EXT_W-1:0]        abs_ext;
  logic signed [EXT_W-1:0] rel_off;
  logic [PC_W-1:0]         target;
  logic [CNT_W-1:0]        cnt_inc;

  always_comb begin
    abs_ext = EXT_W'(branch_val);
    rel_off = EXT_W'($signed(branch_val));
    target  = branch_rel ? (pc_q + rel_off[PC_W-1:0]) : abs_ext[PC_W-1:0];
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          cnt_d = cnt_inc;
          if (halt) begin
            state_d = ST_HALT;
          end else if (branch_taken) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they track
    // the state register exactly with no input-to-output path.
    fetch_valid_d = (state_d == ST_RUN);
    done_d        = (state_d == ST_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= START_ADDR;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign done        = done_q;
  assign inst_count  = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic compared
// against a behavioural model of two instances (default and CNT_W=4/START_ADDR=0x40).
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic        branch_rel = 1'b0;
  logic [7:0]  branch_val = 8'h00;

  logic [7:0]  pc_a, pc_b;
  logic        fv_a, fv_b, done_a, done_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_unit dut_a (
    .clock(clock), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_rel(branch_rel), .branch_val(branch_val),
    .pc(pc_a), .fetch_valid(fv_a), .done(done_a), .inst_count(cnt_a)
  );

  fetch_unit #(.PC_W(8), .START_ADDR(8'h40), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_rel(branch_rel), .branch_val(branch_val),
    .pc(pc_b), .fetch_valid(fv_b), .done(done_b), .inst_count(cnt_b)
  );

  // Behavioural model: both instances see the same inputs, so they share a mode.
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_e;
  mode_e m_mode = M_IDLE;
  int m_pc_a = 0, m_pc_b = 'h40, m_cnt_a = 0, m_cnt_b = 0;

  function automatic int next_target(int cur);
    int off;
    off = int'($signed(branch_val));
    return branch_rel ? ((cur + off) & 255) : int'(branch_val);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_mode = M_IDLE; m_pc_a = 0; m_pc_b = 'h40; m_cnt_a = 0; m_cnt_b = 0;
    end else if (m_mode != M_RUN) begin
      if (start) begin
        m_mode = M_RUN; m_pc_a = 0; m_pc_b = 'h40; m_cnt_a = 0; m_cnt_b = 0;
      end
    end else if (!stall) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 15) m_cnt_b++;
      if (halt) begin
        m_mode = M_HALT;
      end else if (branch_taken) begin
        m_pc_a = next_target(m_pc_a);
        m_pc_b = next_target(m_pc_b);
      end else begin
        m_pc_a = (m_pc_a + 1) % 256;
        m_pc_b = (m_pc_b + 1) % 256;
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0; stall = 0; halt = 0; branch_taken = 0; branch_rel = 0;
  endtask

  task automatic jump_abs(input logic [7:0] dest);
    branch_taken = 1; branch_rel = 0; branch_val = dest;
    tick();
    branch_taken = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 1; halt = 1;
    tick();
    idle_inputs();
    checks++;
    if (pc_a !== 8'h00 || cnt_a !== 16'h0) begin
      errors++; $display("FAIL reset_pc_cnt got pc=%h cnt=%h exp pc=00 cnt=0000", pc_a, cnt_a);
    end
    checks++;
    if (fv_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL reset_flags got fv=%b done=%b exp 0 0", fv_a, done_a);
    end
    checks++;
    if (pc_b !== 8'h40) begin
      errors++; $display("FAIL reset_pc_b got %h exp 40", pc_b);
    end
    tick();
    checks++;
    if (fv_a !== 1'b0 || pc_a !== 8'h00) begin
      errors++; $display("FAIL idle_hold got fv=%b pc=%h exp 0 00", fv_a, pc_a);
    end
  endtask

  task automatic test_start_count();
    start = 1;
    tick();
    start = 0;
    checks++;
    if (pc_a !== 8'h00 || fv_a !== 1'b1 || cnt_a !== 16'h0) begin
      errors++; $display("FAIL start got pc=%h fv=%b cnt=%h exp 00 1 0000", pc_a, fv_a, cnt_a);
    end
    repeat (5) tick();
    checks++;
    if (pc_a !== 8'h05 || cnt_a !== 16'd5) begin
      errors++; $display("FAIL count5 got pc=%h cnt=%0d exp 05 5", pc_a, cnt_a);
    end
    checks++;
    if (pc_b !== 8'h45) begin
      errors++; $display("FAIL count5_b got pc=%h exp 45", pc_b);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [2] = '{8'hFF, 8'h00};
    jump_abs(8'hFE);
    checks++;
    if (pc_a !== 8'hFE) begin
      errors++; $display("FAIL wrap_setup got %h exp fe", pc_a);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pc_a !== exp_pc[i] || fv_a !== 1'b1) begin
        errors++; $display("FAIL wrap_step%0d got pc=%h fv=%b exp %h 1", i, pc_a, fv_a, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [7:0] base [3] = '{8'h20, 8'h10, 8'hFE};
    logic       rel  [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] val  [3] = '{8'h7A, 8'hFC, 8'h05};
    logic [7:0] exp  [3] = '{8'h7A, 8'h0C, 8'h03};
    logic [15:0] c;
    for (int i = 0; i < 3; i++) begin
      jump_abs(base[i]);
      c = cnt_a;
      branch_taken = 1; branch_rel = rel[i]; branch_val = val[i];
      tick();
      branch_taken = 0;
      checks++;
      if (pc_a !== exp[i] || cnt_a !== c + 16'd1) begin
        errors++; $display("FAIL branch%0d got pc=%h cnt=%h exp %h %h", i, pc_a, cnt_a, exp[i], c + 16'd1);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0]  p;
    logic [15:0] c;
    p = pc_a; c = cnt_a;
    stall = 1; branch_taken = 1; halt = 1; start = 1; branch_val = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_a !== p || cnt_a !== c || fv_a !== 1'b1 || done_a !== 1'b0) begin
        errors++; $display("FAIL stall%0d got pc=%h cnt=%h fv=%b done=%b exp %h %h 1 0",
                           i, pc_a, cnt_a, fv_a, done_a, p, c);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (pc_a !== p + 8'd1 || cnt_a !== c + 16'd1) begin
      errors++; $display("FAIL stall_release got pc=%h cnt=%h exp %h %h", pc_a, cnt_a, p + 8'd1, c + 16'd1);
    end
  endtask

  task automatic test_halt_branch();
    logic [15:0] c;
    jump_abs(8'h30);
    c = cnt_a;
    halt = 1; branch_taken = 1; branch_rel = 0; branch_val = 8'h55;
    tick();
    idle_inputs();
    checks++;
    if (done_a !== 1'b1 || fv_a !== 1'b0 || pc_a !== 8'h30 || cnt_a !== c + 16'd1) begin
      errors++; $display("FAIL halt got done=%b fv=%b pc=%h cnt=%h exp 1 0 30 %h",
                         done_a, fv_a, pc_a, cnt_a, c + 16'd1);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || pc_a !== 8'h30 || cnt_a !== c + 16'd1) begin
      errors++; $display("FAIL halt_hold got done=%b pc=%h cnt=%h exp 1 30 %h", done_a, pc_a, cnt_a, c + 16'd1);
    end
    start = 1;
    tick();
    start = 0;
    checks++;
    if (pc_a !== 8'h00 || cnt_a !== 16'h0 || fv_a !== 1'b1 || done_a !== 1'b0) begin
      errors++; $display("FAIL restart got pc=%h cnt=%h fv=%b done=%b exp 00 0000 1 0", pc_a, cnt_a, fv_a, done_a);
    end
  endtask

  task automatic test_saturation();
    reset = 1;
    tick();
    reset = 0; start = 1;
    tick();
    start = 0;
    repeat (20) tick();
    checks++;
    if (cnt_b !== 4'hF) begin
      errors++; $display("FAIL saturate got %h exp f", cnt_b);
    end
    checks++;
    if (cnt_a !== 16'd20 || pc_b !== 8'h54) begin
      errors++; $display("FAIL count20 got cnt=%0d pc_b=%h exp 20 54", cnt_a, pc_b);
    end
  endtask

  task automatic test_reset_mid_run();
    reset = 1; start = 1; halt = 1;
    tick();
    idle_inputs();
    checks++;
    if (fv_a !== 1'b0 || pc_a !== 8'h00 || cnt_a !== 16'h0 || done_a !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run got fv=%b pc=%h cnt=%h done=%b exp 0 00 0000 0",
                         fv_a, pc_a, cnt_a, done_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(63) == 0);
      start        = ($urandom_range(7) == 0);
      stall        = ($urandom_range(3) == 0);
      halt         = ($urandom_range(15) == 0);
      branch_taken = ($urandom_range(3) == 0);
      branch_rel   = 1'($urandom);
      branch_val   = 8'($urandom);
      tick();
      checks++;
      if (pc_a !== 8'(m_pc_a) || cnt_a !== 16'(m_cnt_a) ||
          fv_a !== (m_mode == M_RUN) || done_a !== (m_mode == M_HALT)) begin
        errors++; $display("FAIL random_a cyc %0d got pc=%h cnt=%h fv=%b done=%b exp %h %h %b %b",
                           n, pc_a, cnt_a, fv_a, done_a, 8'(m_pc_a), 16'(m_cnt_a),
                           m_mode == M_RUN, m_mode == M_HALT);
      end
      checks++;
      if (pc_b !== 8'(m_pc_b) || cnt_b !== 4'(m_cnt_b) ||
          fv_b !== (m_mode == M_RUN) || done_b !== (m_mode == M_HALT)) begin
        errors++; $display("FAIL random_b cyc %0d got pc=%h cnt=%h fv=%b done=%b exp %h %h %b %b",
                           n, pc_b, cnt_b, fv_b, done_b, 8'(m_pc_b), 4'(m_cnt_b),
                           m_mode == M_RUN, m_mode == M_HALT);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_wrap();
    test_branch();
    test_stall();
    test_halt_branch();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
